// File: rtl/stone_placer_if.sv
// Bundles the game-flow, point-calculation handshake and board-memory signals of stone_placer.
// The placer connects through master; the surrounding system (or a bench) connects through slave.
interface stone_placer_if;
   logic       start;
   logic       humanValid;
   logic [4:0] humanX;
   logic [4:0] humanY;
   logic       enaPointCal;
   logic       donePointCal;
   logic [4:0] XlocClick;
   logic [4:0] YlocClick;
   logic [4:0] boardRdX;
   logic [4:0] boardRdY;
   logic [1:0] boardRdData;
   logic       boardWe;
   logic [4:0] boardWrX;
   logic [4:0] boardWrY;
   logic [1:0] boardWrData;
   logic       turn;
   logic [1:0] stonesLeft;
   logic [8:0] stoneCount;
   logic       placeDone;
   logic       illegal;
   logic       gameOver;
   logic       aiFault;

   modport master (
      input  start, humanValid, humanX, humanY, donePointCal, XlocClick, YlocClick, boardRdData,
      output enaPointCal, boardRdX, boardRdY, boardWe, boardWrX, boardWrY, boardWrData,
             turn, stonesLeft, stoneCount, placeDone, illegal, gameOver, aiFault
   );

   modport slave (
      output start, humanValid, humanX, humanY, donePointCal, XlocClick, YlocClick, boardRdData,
      input  enaPointCal, boardRdX, boardRdY, boardWe, boardWrX, boardWrY, boardWrData,
             turn, stonesLeft, stoneCount, placeDone, illegal, gameOver, aiFault
   );
endinterface

// File: rtl/stone_placer.sv
// Connect6-style move sequencer: takes human or AI moves, validates them against the board,
// writes the stone and tracks whose turn it is, stones owed this turn and the board fill level.
module stone_placer #(
   parameter int BRD_W    = 19,
   parameter int BRD_H    = 19,
   parameter int AI_COLOR = 1
) (
   input logic            clk,
   input logic            reset,
   stone_placer_if.master bus
);

   localparam logic [8:0] CELLS   = 9'(BRD_W * BRD_H);
   localparam logic [5:0] W_LIM   = 6'(BRD_W);
   localparam logic [5:0] H_LIM   = 6'(BRD_H);
   localparam logic       AI_SIDE = 1'(AI_COLOR);

   typedef enum logic [3:0] {
      IDLE, WAIT_MOVE, AI_REQ, AI_WAIT, CHECK_RD, CHECK_EVAL, WRITE, ADVANCE, FULL
   } state_t;

   state_t     state_q, state_d;
   logic [1:0] sync_q;
   logic [4:0] x_q, x_d;
   logic [4:0] y_q, y_d;
   logic       turn_q, turn_d;
   logic [1:0] left_q, left_d;
   logic [8:0] cnt_q, cnt_d;
   logic       fault_q, fault_d;
   logic       move_bad;

   // Reset asserts asynchronously but releases two edges later, so the FSM never leaves on a runt edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) sync_q <= 2'b00;
      else        sync_q <= {sync_q[0], 1'b1};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         turn_q  <= 1'b0;
         left_q  <= 2'd0;
         cnt_q   <= 9'd0;
         fault_q <= 1'b0;
      end else if (!sync_q[1]) begin
         state_q <= IDLE;
         turn_q  <= 1'b0;
         left_q  <= 2'd0;
         cnt_q   <= 9'd0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         turn_q  <= turn_d;
         left_q  <= left_d;
         cnt_q   <= cnt_d;
         fault_q <= fault_d;
      end
   end

   // Move coordinates are pure data; they are only visible on the ports in the states that use them.
   always_ff @(posedge clk) begin
      x_q <= x_d;
      y_q <= y_d;
   end

   assign move_bad = ({1'b0, x_q} >= W_LIM) || ({1'b0, y_q} >= H_LIM) || (bus.boardRdData != 2'b00);

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      turn_d  = turn_q;
      left_d  = left_q;
      cnt_d   = cnt_q;
      fault_d = fault_q;
      case (state_q)
         IDLE, FULL: begin
            if (bus.start) begin
               state_d = WAIT_MOVE;
               turn_d  = 1'b0;
               left_d  = 2'd1;
               cnt_d   = 9'd0;
               fault_d = 1'b0;
            end
         end
         WAIT_MOVE: begin
            if (turn_q == AI_SIDE) begin
               state_d = AI_REQ;
            end else if (bus.humanValid) begin
               x_d     = bus.humanX;
               y_d     = bus.humanY;
               state_d = CHECK_RD;
            end
         end
         AI_REQ: state_d = AI_WAIT;
         AI_WAIT: begin
            if (bus.donePointCal) begin
               x_d     = bus.XlocClick;
               y_d     = bus.YlocClick;
               state_d = CHECK_RD;
            end
         end
         CHECK_RD: state_d = CHECK_EVAL;
         CHECK_EVAL: begin
            if (!move_bad) begin
               state_d = WRITE;
            end else if (turn_q == AI_SIDE) begin
               fault_d = 1'b1;
               state_d = IDLE;
            end else begin
               state_d = WAIT_MOVE;
            end
         end
         WRITE: begin
            if (cnt_q != CELLS) cnt_d = cnt_q + 9'd1;
            if (left_q != 2'd0) left_d = left_q - 2'd1;
            state_d = ADVANCE;
         end
         ADVANCE: begin
            if (cnt_q == CELLS) begin
               state_d = FULL;
            end else begin
               // After the single opening stone every turn owes two stones.
               if (left_q == 2'd0) begin
                  turn_d = ~turn_q;
                  left_d = 2'd2;
               end
               state_d = WAIT_MOVE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.enaPointCal = 1'b0;
      bus.boardRdX    = 5'd0;
      bus.boardRdY    = 5'd0;
      bus.boardWe     = 1'b0;
      bus.boardWrX    = 5'd0;
      bus.boardWrY    = 5'd0;
      bus.boardWrData = 2'b00;
      bus.placeDone   = 1'b0;
      bus.illegal     = 1'b0;
      bus.turn        = turn_q;
      bus.stonesLeft  = left_q;
      bus.stoneCount  = cnt_q;
      bus.aiFault     = fault_q;
      bus.gameOver    = (state_q == FULL);
      case (state_q)
         AI_REQ:     bus.enaPointCal = 1'b1;
         CHECK_RD: begin
            bus.boardRdX = x_q;
            bus.boardRdY = y_q;
         end
         CHECK_EVAL: bus.illegal = move_bad;
         WRITE: begin
            bus.boardWe     = 1'b1;
            bus.boardWrX    = x_q;
            bus.boardWrY    = y_q;
            bus.boardWrData = {turn_q, ~turn_q};
         end
         ADVANCE:    bus.placeDone = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_stone_placer.sv
// Directed bench for stone_placer: a move table for a short game, plus hand-written
// sequences for reset, AI fault recovery, abort during AI wait and a full-board game.
module tb_stone_placer;

   logic clk;
   logic reset;
   logic board_clr;

   stone_placer_if bus ();

   stone_placer #(.BRD_W(19), .BRD_H(19), .AI_COLOR(1)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Board memory with a one-cycle registered read, as seen by the placer.
   logic [1:0] board [32][32];
   always @(posedge clk) begin
      if (board_clr) begin
         for (int i = 0; i < 32; i++)
            for (int j = 0; j < 32; j++)
               board[i][j] <= 2'b00;
      end else if (bus.boardWe) begin
         board[bus.boardWrX][bus.boardWrY] <= bus.boardWrData;
      end
      bus.boardRdData <= board[bus.boardRdX][bus.boardRdY];
   end

   int   we_count = 0;
   logic overlap  = 1'b0;
   always @(negedge clk) begin
      if (bus.boardWe) we_count <= we_count + 1;
      if (bus.boardWe && bus.enaPointCal) overlap <= 1'b1;
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] outs();
      return 64'({bus.enaPointCal, bus.boardRdX, bus.boardRdY, bus.boardWe, bus.boardWrX,
                  bus.boardWrY, bus.boardWrData, bus.turn, bus.stonesLeft, bus.stoneCount,
                  bus.placeDone, bus.illegal, bus.gameOver, bus.aiFault});
   endfunction

   function automatic logic [63:0] status();
      return 64'({bus.turn, bus.stonesLeft, bus.stoneCount, bus.aiFault, bus.gameOver});
   endfunction

   // Results of the most recent do_move call.
   logic       r_ai, r_ena_ok;
   int         r_kwe, r_kpd, r_kill, r_nwe;
   logic [4:0] r_wx, r_wy;
   logic [1:0] r_wd;

   // Offers one move for whichever side is to move; k counts negedges after the strobe.
   task automatic do_move(input logic [4:0] x, input logic [4:0] y);
      int w;
      r_kwe = -1; r_kpd = -1; r_kill = -1; r_nwe = 0; r_ena_ok = 1'b1;
      r_wx = 5'd0; r_wy = 5'd0; r_wd = 2'b00;
      @(negedge clk);
      r_ai = bus.turn;
      if (r_ai) begin
         w = 0;
         while (!bus.enaPointCal && w < 20) begin
            @(negedge clk);
            w++;
         end
         if (!bus.enaPointCal) r_ena_ok = 1'b0;
         @(negedge clk);
         if (bus.enaPointCal) r_ena_ok = 1'b0;
         bus.donePointCal = 1'b1;
         bus.XlocClick    = x;
         bus.YlocClick    = y;
      end else begin
         bus.humanValid = 1'b1;
         bus.humanX     = x;
         bus.humanY     = y;
      end
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         bus.humanValid   = 1'b0;
         bus.donePointCal = 1'b0;
         if (bus.boardWe) begin
            r_nwe++;
            if (r_kwe < 0) begin
               r_kwe = k; r_wx = bus.boardWrX; r_wy = bus.boardWrY; r_wd = bus.boardWrData;
            end
         end
         if (bus.illegal && r_kill < 0) r_kill = k;
         if (bus.placeDone) begin
            r_kpd = k;
            break;
         end
         if (r_kill >= 0) break;
      end
   endtask

   task automatic pulse_start();
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   typedef struct {
      logic       ai;
      logic [4:0] x;
      logic [4:0] y;
      logic       ill;
      logic [1:0] wd;
      logic       turn;
      logic [1:0] left;
      logic [8:0] cnt;
      logic       fault;
   } vec_t;

   vec_t tbl [10];

   initial begin
      int base, bad, n_we, n_pd, n_ill, n_ena;
      logic [4:0] fx, fy;

      tbl[0] = '{1'b0, 5'd9,  5'd9,  1'b0, 2'b01, 1'b1, 2'd2, 9'd1, 1'b0};
      tbl[1] = '{1'b1, 5'd3,  5'd4,  1'b0, 2'b10, 1'b1, 2'd1, 9'd2, 1'b0};
      tbl[2] = '{1'b1, 5'd3,  5'd5,  1'b0, 2'b10, 1'b0, 2'd2, 9'd3, 1'b0};
      tbl[3] = '{1'b0, 5'd3,  5'd4,  1'b1, 2'b00, 1'b0, 2'd2, 9'd3, 1'b0};
      tbl[4] = '{1'b0, 5'd19, 5'd0,  1'b1, 2'b00, 1'b0, 2'd2, 9'd3, 1'b0};
      tbl[5] = '{1'b0, 5'd0,  5'd19, 1'b1, 2'b00, 1'b0, 2'd2, 9'd3, 1'b0};
      tbl[6] = '{1'b0, 5'd0,  5'd0,  1'b0, 2'b01, 1'b0, 2'd1, 9'd4, 1'b0};
      tbl[7] = '{1'b0, 5'd18, 5'd18, 1'b0, 2'b01, 1'b1, 2'd2, 9'd5, 1'b0};
      tbl[8] = '{1'b1, 5'd18, 5'd0,  1'b0, 2'b10, 1'b1, 2'd1, 9'd6, 1'b0};
      tbl[9] = '{1'b1, 5'd19, 5'd0,  1'b1, 2'b00, 1'b1, 2'd1, 9'd6, 1'b1};

      reset = 1'b1; board_clr = 1'b0;
      bus.start = 1'b0; bus.humanValid = 1'b0; bus.humanX = 5'd0; bus.humanY = 5'd0;
      bus.donePointCal = 1'b0; bus.XlocClick = 5'd0; bus.YlocClick = 5'd0;

      #3 reset = 1'b0;
      #2 check("reset outputs", outs(), 64'd0);
      @(negedge clk) board_clr = 1'b1;
      @(negedge clk) board_clr = 1'b0;
      @(negedge clk) reset = 1'b1;
      repeat (3) @(negedge clk);
      check("idle after release", outs(), 64'd0);

      pulse_start();
      check("new game status", status(), 64'({1'b0, 2'd1, 9'd0, 1'b0, 1'b0}));

      for (int i = 0; i < 10; i++) begin
         do_move(tbl[i].x, tbl[i].y);
         check($sformatf("v%0d side", i), 64'(r_ai), 64'(tbl[i].ai));
         if (tbl[i].ai) check($sformatf("v%0d enaPointCal single", i), 64'(r_ena_ok), 64'd1);
         if (tbl[i].ill) begin
            check($sformatf("v%0d illegal latency", i), 64'(r_kill), 64'd2);
            check($sformatf("v%0d write count", i), 64'(r_nwe), 64'd0);
         end else begin
            check($sformatf("v%0d write latency", i), 64'(r_kwe), 64'd3);
            check($sformatf("v%0d placeDone latency", i), 64'(r_kpd), 64'd4);
            check($sformatf("v%0d write count", i), 64'(r_nwe), 64'd1);
            check($sformatf("v%0d write x/y/data", i), 64'({r_wx, r_wy, r_wd}),
                  64'({tbl[i].x, tbl[i].y, tbl[i].wd}));
         end
         @(negedge clk);
         check($sformatf("v%0d turn/left/count/fault", i),
               64'({bus.turn, bus.stonesLeft, bus.stoneCount, bus.aiFault}),
               64'({tbl[i].turn, tbl[i].left, tbl[i].cnt, tbl[i].fault}));
      end

      // AI fault leaves the FSM idle until a new game clears the flag.
      pulse_start();
      check("fault cleared by start", status(), 64'({1'b0, 2'd1, 9'd0, 1'b0, 1'b0}));

      // Reset arriving while the AI is thinking aborts the move.
      do_move(5'd5, 5'd5);
      check("pre-abort human move", 64'(r_kpd), 64'd4);
      @(negedge clk);
      @(negedge clk);
      check("abort AI_REQ reached", 64'(bus.enaPointCal), 64'd1);
      @(negedge clk);
      #2 reset = 1'b0;
      #1 check("outputs during mid-move reset", outs(), 64'd0);
      bus.donePointCal = 1'b1; bus.XlocClick = 5'd7; bus.YlocClick = 5'd7;
      @(negedge clk);
      @(negedge clk);
      bus.donePointCal = 1'b0;
      reset = 1'b1;
      n_we = 0; n_pd = 0; n_ena = 0;
      @(negedge clk) bus.donePointCal = 1'b1;
      @(negedge clk) bus.donePointCal = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (bus.boardWe) n_we++;
         if (bus.placeDone) n_pd++;
         if (bus.enaPointCal) n_ena++;
      end
      check("no activity after abort", 64'({8'(n_we), 8'(n_pd), 8'(n_ena)}), 64'd0);
      check("idle outputs after abort", outs(), 64'd0);

      // Full-board game.
      @(negedge clk) board_clr = 1'b1;
      @(negedge clk) board_clr = 1'b0;
      pulse_start();
      base = we_count;
      bad = 0;
      for (int idx = 0; idx < 361; idx++) begin
         fx = 5'(idx % 19);
         fy = 5'(idx / 19);
         do_move(fx, fy);
         if (r_kill >= 0 || r_kwe != 3 || r_kpd != 4 || r_nwe != 1 || (r_ai && !r_ena_ok)) bad++;
         if (idx == 2) begin
            pulse_start();
            check("start ignored mid-game", 64'({bus.turn, bus.stonesLeft, bus.stoneCount}),
                  64'({1'b0, 2'd2, 9'd3}));
         end
      end
      check("fill moves accepted", 64'(bad), 64'd0);
      @(negedge clk);
      check("gameOver after last stone", 64'(bus.gameOver), 64'd1);
      check("stoneCount full", 64'(bus.stoneCount), 64'd361);
      check("writes in full game", 64'(we_count - base), 64'd361);

      n_we = 0; n_pd = 0; n_ill = 0;
      @(negedge clk) begin bus.humanValid = 1'b1; bus.humanX = 5'd0; bus.humanY = 5'd0; end
      @(negedge clk) bus.humanValid = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (bus.boardWe) n_we++;
         if (bus.placeDone) n_pd++;
         if (bus.illegal) n_ill++;
      end
      check("humanValid ignored when full", 64'({8'(n_we), 8'(n_pd), 8'(n_ill)}), 64'd0);
      check("full state held", 64'({bus.gameOver, bus.stoneCount}), 64'({1'b1, 9'd361}));

      pulse_start();
      check("restart from full", status(), 64'({1'b0, 2'd1, 9'd0, 1'b0, 1'b0}));
      check("write never with enaPointCal", 64'(overlap), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
